// File: rtl/uart_rx_frame.sv
// uart_rx_frame: receives 11-bit UART frames (start, 8 data LSB-first,
// parity, stop) and presents each byte with a one-cycle completion strobe.
// Ports:
//   clk_3125    - 3.125 MHz system clock, rising edge
//   rst_n       - synchronous active-low reset
//   rx          - asynchronous serial line, idle high
//   parity_type - 0 = even, 1 = odd expected parity (latched at start)
//   rx_msg      - received byte, bit 0 = first data bit on the wire
//   rx_parity   - parity bit as received
//   rx_complete - one-cycle pulse when a frame finishes
//   parity_err  - parity mismatch, valid with rx_complete
//   frame_err   - stop bit sampled low, valid with rx_complete
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 28,
    parameter int unsigned SAMPLE_POINT = 14,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       parity_type,
    output logic [7:0] rx_msg,
    output logic       rx_parity,
    output logic       rx_complete,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_d;
    logic [CNT_W-1:0]       counter;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic                   par_q;
    logic                   ptype_q;
    logic                   sample;
    logic                   wrap;

    assign rx_s   = sync[SYNC_STAGES-1];
    assign sample = (counter == CNT_W'(SAMPLE_POINT));
    assign wrap   = (counter == CNT_W'(CLKS_PER_BIT - 1));

    // Synchronizer, bit timing and frame FSM with registered outputs
    always_ff @(posedge clk_3125) begin
        if (!rst_n) begin
            sync        <= '1;
            rx_d        <= 1'b1;
            state       <= IDLE;
            counter     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            par_q       <= 1'b0;
            ptype_q     <= 1'b0;
            rx_msg      <= '0;
            rx_parity   <= 1'b0;
            rx_complete <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], rx};
            rx_d        <= rx_s;
            rx_complete <= 1'b0;

            if (state != IDLE) begin
                counter <= wrap ? '0 : counter + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    // Only a genuine 1->0 transition starts a frame
                    if (rx_d && !rx_s) begin
                        counter <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            ptype_q <= parity_type;
                        end
                    end else if (wrap) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift[bit_idx] <= rx_s;
                    end
                    if (wrap) begin
                        if (bit_idx == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample) begin
                        par_q <= rx_s;
                    end
                    if (wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Finish mid-stop so a back-to-back start edge is seen
                    if (sample) begin
                        rx_msg      <= shift;
                        rx_parity   <= par_q;
                        parity_err  <= ((^shift) ^ par_q) != ptype_q;
                        frame_err   <= ~rx_s;
                        rx_complete <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames with hand-computed expectations pushed
// into a scoreboard queue; a negedge monitor pops and compares on each
// rx_complete pulse.
module tb_uart_rx_frame;

    localparam int unsigned CPB = 28;

    logic       clk_3125 = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       parity_type;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       rx_complete;
    logic       parity_err;
    logic       frame_err;

    always #5 clk_3125 = ~clk_3125;

    uart_rx_frame dut (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .rx          (rx),
        .parity_type (parity_type),
        .rx_msg      (rx_msg),
        .rx_parity   (rx_parity),
        .rx_complete (rx_complete),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    typedef struct {
        logic [7:0]  msg;
        logic        par;
        logic        perr;
        logic        ferr;
        int unsigned t0;
    } exp_t;

    exp_t        expq[$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_c = 1'b0;
    exp_t        e;
    int unsigned lat;

    always @(posedge clk_3125) cyc <= cyc + 1;

    function automatic void chk(input string name, input int unsigned act,
                                input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endfunction

    // Monitor: pops one expectation per completion pulse
    always @(negedge clk_3125) begin
        if (rx_complete) begin
            checks++;
            if (prev_c) begin
                errors++;
                $display("FAIL pulse_width: rx_complete high in consecutive cycles, required single cycle");
            end
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: actual pulse with rx_msg=0x%02h, required no pulse", rx_msg);
            end else begin
                e = expq.pop_front();
                chk("rx_msg", 32'(rx_msg), 32'(e.msg));
                chk("rx_parity", 32'(rx_parity), 32'(e.par));
                chk("parity_err", 32'(parity_err), 32'(e.perr));
                chk("frame_err", 32'(frame_err), 32'(e.ferr));
                lat = cyc - e.t0;
                checks++;
                if (lat < 297 || lat > 299) begin
                    errors++;
                    $display("FAIL latency: actual %0d cycles required 297..299", lat);
                end
            end
        end
        prev_c = rx_complete;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk_3125);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk_3125);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit,
                              input logic sbit, input logic ptype,
                              input logic xperr, input logic xferr);
        exp_t x;
        parity_type = ptype;
        x.msg  = data;
        x.par  = pbit;
        x.perr = xperr;
        x.ferr = xferr;
        x.t0   = cyc;
        expq.push_back(x);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(pbit);
        drive_bit(sbit);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && expq.size() != 0; i++) @(negedge clk_3125);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: actual %0d frames pending, required 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rx_msg"}, 32'(rx_msg), 32'h0);
        chk({tag, "_rx_parity"}, 32'(rx_parity), 32'h0);
        chk({tag, "_rx_complete"}, 32'(rx_complete), 32'h0);
        chk({tag, "_parity_err"}, 32'(parity_err), 32'h0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        rx          = 1'b1;
        parity_type = 1'b0;
        repeat (3) @(negedge clk_3125);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(5);

        // Clean frame 0xA5, even parity, parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        idle(20);

        // Wrong parity bit under even parity, then accepted under odd
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_drain();
        idle(20);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_drain();
        idle(20);

        // Stop bit low, line held low, no second frame
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (100) @(negedge clk_3125);
        idle(40);
        wait_drain();

        // Short start glitch is discarded; following frame is good
        rx = 1'b0;
        repeat (10) @(negedge clk_3125);
        idle(30);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        idle(20);

        // Back-to-back frames with no idle gap
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        idle(20);

        // Reset during data bit 4 of 0xFF: frame discarded, outputs cleared
        rx = 1'b0;
        repeat (CPB) @(negedge clk_3125);
        rx = 1'b1;
        repeat (CPB * 4 + 10) @(negedge clk_3125);
        rst_n = 1'b0;
        @(negedge clk_3125);
        rst_n = 1'b1;
        idle(400);
        check_zero_outputs("mid_reset");
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        idle(20);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL final_queue: actual %0d pending, required 0", expq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
